spart_rx: RTL
=============

# spart_rx

Serial receive stage of the SPART. It consumes the 16x-oversampled baud enable `en` from the baud generator and deserialises asynchronous 8N1 frames from `rxd`, LSB first. It holds each received byte in a one-deep buffer, with receive-data-available, framing-error and overrun flags. The processor reads the byte over the SPART IO bus, and that read releases the buffer.

## Interface
- `OVERSAMPLE`, 16: baud enables per bit time; power of two, ≥4.
- `DATA_BITS`, 8: data bits per frame.
- `clk` input 1: system clock. One clock domain; reset is asynchronous and active-high.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: baud tick from the baud generator, one-cycle pulse, OVERSAMPLE ticks per bit.
- `rxd` input 1: serial line, idle high, asynchronous to `clk`.
- `iocs` input 1: chip select.
- `iorw` input 1: 1 = read.
- `ioaddr` input 2: register select. `2'b00` is the receive buffer.
- `rx_data` output DATA_BITS: received byte buffer.
- `rda` output 1: receive data available.
- `frame_err` output 1: sticky framing error.
- `overrun` output 1: sticky overrun.
- `parity_err` output 1: sticky parity error. Present only with `SPART_RX_PARITY_EN`.

## Operation
- **Synchroniser.** `rxd` passes through two flops, both reset to 1. All logic uses the synchronised value `rxs` and its previous value `rxs_d`.
- **Data read.** A data read is `iocs & iorw & ioaddr==2'b00` in a cycle. It clears `rda`, `frame_err`, `overrun` and `parity_err` at the next edge.
- **State machine: IDLE, START, DATA, [PARITY], STOP.**
  - Sample counter `scnt` is log2(OVERSAMPLE) bits. It advances only on `en`.
  - IDLE: on a falling edge (`rxs_d & ~rxs`), go to START and clear `scnt`. A held-low line (break) does not retrigger.
  - START: when `en` fires and `scnt==OVERSAMPLE/2-1`, clear `scnt`. If `rxs==0`, go to DATA with bit count cleared. Otherwise it is a glitch: return to IDLE.
  - DATA: when `en` fires and `scnt==OVERSAMPLE-1`, shift `rxs` into the MSB of the shift register (LSB-first frame) and increment the bit count. After DATA_BITS samples, go to PARITY if enabled, otherwise STOP.
  - STOP: sample at `scnt==OVERSAMPLE-1`, then always return to IDLE.
    - If `rxs==1`: commit the frame.
    - If `rxs==0`: set `frame_err` and discard the byte. `rda` and `rx_data` are unchanged.
- **Commit.**
  - If `rda==0`, or a data read occurs in the same cycle: load `rx_data` and set `rda`.
  - If `rda==1` with no read: discard the new byte, set `overrun` and keep `rx_data` unchanged.
  - A read and a commit in the same cycle leave `rda=1` with the new byte; no overrun.
- **Clear priority.** When a read and a flag-set land in the same cycle, the set wins for that flag. The read clears only flags not being set in that cycle.
- **Reset mid-frame.** The FSM returns to IDLE, the partial byte is lost and all flags clear.

## Timing
- Reset values: `rx_data=0`, `rda=0`, `frame_err=0`, `overrun=0`, `parity_err=0`. Synchroniser flops reset to 1.
- Input latency: 2 `clk` from a `rxd` edge to `rxs`.
- Bit sampling: each data bit is sampled OVERSAMPLE ticks after the previous one, centred at about mid-bit.
- Output timing: `rda` and the flags rise on the `clk` edge immediately after the stop-bit sample tick.
- Reads: `rx_data` is stable while `rda=1` and is valid in the read cycle itself; no wait states.

## Configuration
- `SPART_RX_PARITY_EN` defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - A mismatch sets `parity_err`. The byte is still committed if the stop bit is good.
  - The `parity_err` port exists.
- Undefined: no PARITY state and no `parity_err` port. Frames are 8N1.

## Structure
- Shared package `spart_pkg`:
  - FSM state enum `rx_state_t`.
  - IO address constant `SPART_ADDR_DATA=2'b00`.
  - Defaults `SPART_OVERSAMPLE=16` and `SPART_DATA_BITS=8`.
- One sub-module, `spart_sync2`: the two-flop synchroniser, with a reset value parameter. It is reused by the transmit side's CTS input.

## Test plan
Bench drives `en` every 4 `clk` (16 ticks per bit = 64 `clk`).
- **Single byte.** Send 0xA5 8N1 → `rda=1` one `clk` after the stop sample, `rx_data=8'hA5`. A data read then drops `rda` on the next edge.
- **Start glitch.** Pull `rxd` low for 3 ticks, then high → FSM back in IDLE, `rda=0`. A following byte 0x3C is received correctly.
- **Framing error.** Send 0x55 with the stop bit low → `frame_err=1`, `rda=0`, `rx_data` unchanged. A data read clears `frame_err`.
- **Overrun.** Send 0x11 then 0x22 with no read → `rda=1`, `rx_data=8'h11`, `overrun=1`. A read in the same cycle as the second commit instead gives `rx_data=8'h22` and `overrun=0`.
- **Reset mid-frame.** Pulse `rst` after 4 data bits of 0xF0 → all outputs at reset values. The next byte 0x0F is received as 0x0F.
- **Parity (`SPART_RX_PARITY_EN`).** Send 0x07 with parity bit 0 (wrong) → `parity_err=1`, `rda=1`, `rx_data=8'h07`.

Source files
------------

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types and constants
package spart_pkg;

  localparam int SPART_OVERSAMPLE = 16;
  localparam int SPART_DATA_BITS  = 8;

  localparam logic [1:0] SPART_ADDR_DATA = 2'b00;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/spart_sync2.sv
// rtl/spart_sync2.sv - two-flop synchroniser for an asynchronous input
// RESET_VAL should match the line's idle level so reset does not fake an edge.
module spart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART serial receiver with one-deep buffer and sticky flags
// Define SPART_RX_PARITY_EN to receive one even-parity bit and expose parity_err.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = SPART_OVERSAMPLE,
  parameter int DATA_BITS  = SPART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rxd,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
`ifdef SPART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] SCNT_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_BITS - 1);

  logic rxs;

  rx_state_t              state_q, state_d;
  logic                   rxs_d_q, rxs_d_d;
  logic [SW-1:0]          scnt_q, scnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rda_q, rda_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef SPART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic data_rd, tick_mid, tick_end, commit, fe_set;

  spart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  always_comb begin
    data_rd  = iocs & iorw & (ioaddr == SPART_ADDR_DATA);
    tick_mid = en & (scnt_q == SCNT_HALF);
    tick_end = en & (scnt_q == SCNT_LAST);

    state_d     = state_q;
    rxs_d_d     = rxs;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rda_d       = rda_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    commit      = 1'b0;
    fe_set      = 1'b0;
`ifdef SPART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = parity_err_q;
`endif

    // OVERSAMPLE is a power of two, so the free-running count wraps to 0 on each bit sample.
    if (state_q != RX_IDLE && en) begin
      scnt_d = scnt_q + 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        if (rxs_d_q && !rxs) begin
          state_d = RX_START;
          scnt_d  = '0;
        end
      end
      RX_START: begin
        if (tick_mid) begin
          scnt_d = '0;
          if (!rxs) begin
            state_d = RX_DATA;
            bcnt_d  = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (tick_end) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_LAST) begin
`ifdef SPART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef SPART_RX_PARITY_EN
      RX_PARITY: begin
        if (tick_end) begin
          par_bad_d = rxs ^ (^shift_q);
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (tick_end) begin
          state_d = RX_IDLE;
          commit  = rxs;
          fe_set  = ~rxs;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Read clears first; any flag being set this cycle then overrides the clear.
    if (data_rd) begin
      rda_d       = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef SPART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end

    if (commit) begin
      if (!rda_q || data_rd) begin
        rx_data_d = shift_q;
        rda_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (fe_set) begin
      frame_err_d = 1'b1;
    end

`ifdef SPART_RX_PARITY_EN
    if ((commit || fe_set) && par_bad_q) begin
      parity_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      rxs_d_q     <= 1'b1;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rda_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rxs_d_q     <= rxs_d_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rda_q       <= rda_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SPART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rda       = rda_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef SPART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
